aes_result_viewer: RTL and testbench
====================================

AES_RESULT_VIEWER -- requirements
Module: aes_result_viewer

Interface
REQ-001 SHALL have parameter DATA_W, default 128: width of each result word, a multiple of 4.
REQ-002 SHALL have parameter NUM_CH, default 2: number of result channels (channel 0 = encryption, channel 1 = decryption).
REQ-003 SHALL have parameter NUM_DIGITS, default 6: number of 7-segment digits driven.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable-level count, used only under REQ-025.
REQ-005 SHALL have port CLOCK_50, input, 1: the single clock; all state is on its rising edge.
REQ-006 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port KEY, input, 3: raw active-low pushbuttons; [0]=capture, [1]=next page, [2]=next channel.
REQ-008 SHALL have port ch_data, input, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port ch_valid, input, NUM_CH: channel c result is stable and capturable.
REQ-010 SHALL have port exp_data, input, NUM_CH*DATA_W: expected word per channel, same packing as ch_data.
REQ-011 SHALL have port LEDR, output, NUM_CH: per-channel pass flag.
REQ-012 SHALL have port HEX, output, NUM_DIGITS*7: digit d at [d*7 +: 7], bit order {g,f,e,d,c,b,a}, active-low.

Function
REQ-013 SHALL pass each KEY bit through a 2-flop synchronizer and generate a one-cycle press pulse on each synchronized 1->0 transition.
REQ-014 SHALL implement an FSM with states EMPTY and SHOW; EMPTY exits to SHOW on the first capture pulse and never returns except via reset.
REQ-015 On a capture pulse, SHALL latch ch_data for every channel whose ch_valid is 1; other channels keep their previous latch and flags.
REQ-016 SHALL set LEDR[c] in the same cycle as the latch, to 1 iff the latched word equals exp_data slice c, and SHALL hold it until the next capture of that channel.
REQ-017 SHALL keep a page counter P in 0..NPAGES-1, NPAGES = ceil((DATA_W/4)/NUM_DIGITS); a next-page pulse increments P and wraps NPAGES-1 -> 0.
REQ-018 SHALL keep a channel counter C in 0..NUM_CH-1; a next-channel pulse increments C, wraps NUM_CH-1 -> 0, and clears P to 0.
REQ-019 In SHOW, digit d SHALL display the hex glyph of nibble index P*NUM_DIGITS+d of the latched word for channel C, nibble 0 being bits [3:0]; indices >= DATA_W/4 SHALL show blank (7'h7F).
REQ-020 In EMPTY, every digit SHALL show dash (7'h3F), and page and channel pulses SHALL be ignored.
REQ-021 Simultaneous pulses SHALL resolve as: capture clears P to 0 and suppresses next-page; next-channel takes precedence over next-page.
REQ-022 HEX SHALL be registered, updating one cycle after the state, P or C change that causes it.

Reset
REQ-023 RST_N low SHALL, asynchronously: put the FSM in EMPTY, clear P, C, latched words, LEDR and synchronizers (to released, 1), and drive HEX to all dashes.
REQ-024 Reset asserted mid-operation SHALL discard captured data; after release, one capture pulse is required before data is shown.

Configuration
REQ-025 With macro AES_VIEW_DEBOUNCE_EN defined, SHALL generate a press pulse only after the synchronized level has been stable low for DEBOUNCE_CYCLES cycles, once per press; without the macro, SHALL generate a press pulse on the synchronized falling edge only (REQ-013), with no debounce counter in the design.

Verification (defaults, DEBOUNCE_CYCLES=4 when macro defined)
REQ-026 Reset, no presses -> HEX all 7'h3F, LEDR=2'b00; page and channel presses leave this unchanged.
REQ-027 ch0=exp0=69c4e0d86a7b0430d8cdb78070b4c55a, ch1=exp1=00112233445566778899aabbccddeeff, ch_valid=2'b11, press KEY[0] -> LEDR=2'b11; HEX digits 0..5 show A,5,5,C,4,B.
REQ-028 ch1 corrupted to ...eefe, press KEY[0] -> LEDR=2'b01; press KEY[2] -> digits 0..5 show E,F,E,E,D,D with P=0.
REQ-029 Press KEY[1] five times on channel 0 -> page 5 digits 0,1 show 9,6, digits 2..5 blank; sixth press wraps to page 0.
REQ-030 KEY[0] and KEY[1] pressed in the same cycle with ch_valid=2'b01 -> only ch0 re-latched, P=0; RST_N low mid-page -> dashes, LEDR=0 immediately.
REQ-031 Macro defined: KEY[0] bouncing 3 cycles low, 1 high, then held 4 low -> exactly one capture pulse; macro undefined, same stimulus -> two pulses.

Source files
------------

// File: rtl/aes_result_viewer.sv
// aes_result_viewer: captures per-channel AES result words, flags them against expected values
// and pages the latched word onto 7-segment digits. Macro AES_VIEW_DEBOUNCE_EN enables button debounce.
module aes_result_viewer #(
   parameter int DATA_W          = 128,
   parameter int NUM_CH          = 2,
   parameter int NUM_DIGITS      = 6,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                       CLOCK_50,
   input  logic                       RST_N,
   input  logic [2:0]                 KEY,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   input  logic [NUM_CH-1:0]          ch_valid,
   input  logic [NUM_CH*DATA_W-1:0]   exp_data,
   output logic [NUM_CH-1:0]          LEDR,
   output logic [NUM_DIGITS*7-1:0]    HEX
);
   localparam int NIBBLES = DATA_W / 4;
   localparam int NPAGES  = (NIBBLES + NUM_DIGITS - 1) / NUM_DIGITS;
   localparam int PW      = (NPAGES > 1) ? $clog2(NPAGES) : 1;
   localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [6:0] DASH  = 7'h3F;
   localparam logic [6:0] BLANK = 7'h7F;

   typedef enum logic {EMPTY, SHOW} state_t;

   if ((DATA_W % 4) != 0 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("aes_result_viewer: DATA_W must be a multiple of 4 and DEBOUNCE_CYCLES >= 1");
   end

   logic [2:0]        key_s1, key_s2, press;
   logic              cap, nxpg, nxch;
   state_t            state_q, state_d;
   logic [PW-1:0]     page_q, page_d;
   logic [CW-1:0]     chan_q, chan_d;
   logic [NUM_CH-1:0] ledr_q;
   logic [DATA_W-1:0] latched [NUM_CH];
   logic [DATA_W-1:0] cur;
   logic [NUM_DIGITS*7-1:0] hex_q, hex_d;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         key_s1 <= '1;
         key_s2 <= '1;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
      end
   end

`ifdef AES_VIEW_DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [DBW-1:0] db_cnt [3];

   // Counter saturates at DEBOUNCE_CYCLES so a long hold yields a single pulse.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (key_s2[k])
               db_cnt[k] <= '0;
            else if (db_cnt[k] != DBW'(DEBOUNCE_CYCLES))
               db_cnt[k] <= db_cnt[k] + 1'b1;
         end
      end
   end

   always_comb begin
      press = '0;
      for (int k = 0; k < 3; k++)
         press[k] = !key_s2[k] && (db_cnt[k] == DBW'(DEBOUNCE_CYCLES - 1));
   end
`else
   logic [2:0] key_s3;

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) key_s3 <= '1;
      else        key_s3 <= key_s2;
   end

   assign press = key_s3 & ~key_s2;
`endif

   assign cap  = press[0];
   assign nxpg = press[1];
   assign nxch = press[2];

   // Capture resets the page; channel step beats page step when both arrive together.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      chan_d  = chan_q;
      if (state_q == EMPTY) begin
         if (cap) begin
            state_d = SHOW;
            page_d  = '0;
         end
      end else begin
         if (nxch)
            chan_d = (chan_q == CW'(NUM_CH - 1)) ? '0 : chan_q + 1'b1;
         if (cap || nxch)
            page_d = '0;
         else if (nxpg)
            page_d = (page_q == PW'(NPAGES - 1)) ? '0 : page_q + 1'b1;
      end
   end

   always_comb begin
      int idx;
      idx   = 0;
      cur   = latched[chan_q];
      hex_d = {NUM_DIGITS{DASH}};
      if (state_q == SHOW) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            idx = int'(page_q) * NUM_DIGITS + d;
            if (idx >= NIBBLES)
               hex_d[d*7 +: 7] = BLANK;
            else
               hex_d[d*7 +: 7] = seg7(4'(cur >> (idx * 4)));
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         page_q  <= '0;
         chan_q  <= '0;
         ledr_q  <= '0;
         hex_q   <= {NUM_DIGITS{DASH}};
         for (int c = 0; c < NUM_CH; c++) latched[c] <= '0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         chan_q  <= chan_d;
         hex_q   <= hex_d;
         if (cap) begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (ch_valid[c]) begin
                  latched[c] <= ch_data[c*DATA_W +: DATA_W];
                  ledr_q[c]  <= (ch_data[c*DATA_W +: DATA_W] == exp_data[c*DATA_W +: DATA_W]);
               end
            end
         end
      end
   end

   assign LEDR = ledr_q;
   assign HEX  = hex_q;

endmodule

// File: tb/tb_aes_result_viewer.sv
// tb_aes_result_viewer: directed self-checking bench for aes_result_viewer (default build, no debounce).
module tb_aes_result_viewer;
   localparam int DATA_W = 128;
   localparam int NUM_CH = 2;
   localparam int NUM_DIGITS = 6;

   localparam logic [127:0] W0    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] W1    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] W1BAD = 128'h00112233445566778899aabbccddeefe;
   localparam logic [127:0] W2    = 128'h0123456789abcdef0123456789abcdef;
   localparam logic [41:0]  DASHES = {6{7'h3F}};

   logic                     CLOCK_50 = 1'b0;
   logic                     RST_N;
   logic [2:0]               KEY;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH*DATA_W-1:0] exp_data;
   logic [NUM_CH-1:0]        LEDR;
   logic [NUM_DIGITS*7-1:0]  HEX;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   aes_result_viewer #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .NUM_DIGITS(NUM_DIGITS), .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLOCK_50(CLOCK_50), .RST_N(RST_N), .KEY(KEY), .ch_data(ch_data),
      .ch_valid(ch_valid), .exp_data(exp_data), .LEDR(LEDR), .HEX(HEX)
   );

   // Hand-written glyph table: -1 is a blank digit.
   function automatic logic [6:0] glyph(input int v);
      case (v)
         -1: glyph = 7'h7F;
         0: glyph = 7'h40;  1: glyph = 7'h79;  2: glyph = 7'h24;  3: glyph = 7'h30;
         4: glyph = 7'h19;  5: glyph = 7'h12;  6: glyph = 7'h02;  7: glyph = 7'h78;
         8: glyph = 7'h00;  9: glyph = 7'h10; 10: glyph = 7'h08; 11: glyph = 7'h03;
        12: glyph = 7'h46; 13: glyph = 7'h21; 14: glyph = 7'h06; 15: glyph = 7'h0E;
         default: glyph = 7'h3F;
      endcase
   endfunction

   function automatic logic [41:0] digits(input int d0, d1, d2, d3, d4, d5);
      digits = {glyph(d5), glyph(d4), glyph(d3), glyph(d2), glyph(d1), glyph(d0)};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] mask);
      @(negedge CLOCK_50);
      KEY = ~mask;
      repeat (2) @(negedge CLOCK_50);
      KEY = 3'b111;
      repeat (6) @(negedge CLOCK_50);
   endtask

   initial begin
      RST_N    = 1'b0;
      KEY      = 3'b111;
      ch_data  = '0;
      ch_valid = '0;
      exp_data = {W1, W0};
      repeat (3) @(negedge CLOCK_50);
      checkOutput("reset_hex", 64'(HEX), 64'(DASHES));
      checkOutput("reset_ledr", 64'(LEDR), 64'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);

      applyStimulus(3'b010);
      applyStimulus(3'b100);
      checkOutput("empty_ignore_hex", 64'(HEX), 64'(DASHES));
      checkOutput("empty_ignore_ledr", 64'(LEDR), 64'd0);

      ch_data  = {W1, W0};
      ch_valid = 2'b11;
      applyStimulus(3'b001);
      checkOutput("cap_both_ledr", 64'(LEDR), 64'h3);
      checkOutput("cap_ch0_p0", 64'(HEX), 64'(digits(10, 5, 5, 12, 4, 11)));

      ch_data = {W1BAD, W0};
      applyStimulus(3'b001);
      checkOutput("cap_bad_ledr", 64'(LEDR), 64'h1);
      applyStimulus(3'b100);
      checkOutput("ch1_p0", 64'(HEX), 64'(digits(14, 15, 14, 14, 13, 13)));
      applyStimulus(3'b010);
      applyStimulus(3'b100);
      checkOutput("ch_wrap_p0", 64'(HEX), 64'(digits(10, 5, 5, 12, 4, 11)));

      applyStimulus(3'b010);
      checkOutput("ch0_p1", 64'(HEX), 64'(digits(0, 7, 0, 8, 7, 11)));
      applyStimulus(3'b010);
      checkOutput("ch0_p2", 64'(HEX), 64'(digits(13, 12, 8, 13, 0, 3)));
      applyStimulus(3'b010);
      applyStimulus(3'b010);
      applyStimulus(3'b010);
      checkOutput("ch0_p5_blank", 64'(HEX), 64'(digits(9, 6, -1, -1, -1, -1)));
      applyStimulus(3'b010);
      checkOutput("page_wrap", 64'(HEX), 64'(digits(10, 5, 5, 12, 4, 11)));

      applyStimulus(3'b010);
      applyStimulus(3'b010);
      ch_data  = {W1, W2};
      ch_valid = 2'b01;
      applyStimulus(3'b011);
      checkOutput("cap_pg_ledr", 64'(LEDR), 64'h0);
      checkOutput("cap_pg_p0", 64'(HEX), 64'(digits(15, 14, 13, 12, 11, 10)));
      applyStimulus(3'b100);
      checkOutput("ch1_kept", 64'(HEX), 64'(digits(14, 15, 14, 14, 13, 13)));
      applyStimulus(3'b100);
      applyStimulus(3'b010);
      checkOutput("new_ch0_p1", 64'(HEX), 64'(digits(9, 8, 7, 6, 5, 4)));

      @(negedge CLOCK_50);
      RST_N = 1'b0;
      #1;
      checkOutput("async_rst_hex", 64'(HEX), 64'(DASHES));
      checkOutput("async_rst_ledr", 64'(LEDR), 64'd0);
      repeat (2) @(negedge CLOCK_50);
      RST_N = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      applyStimulus(3'b010);
      checkOutput("post_rst_empty", 64'(HEX), 64'(DASHES));

      ch_data  = {W1, W0};
      ch_valid = 2'b01;
      applyStimulus(3'b001);
      checkOutput("recap_ledr", 64'(LEDR), 64'h1);
      checkOutput("recap_p0", 64'(HEX), 64'(digits(10, 5, 5, 12, 4, 11)));

      // Bouncing page button: without debounce each synchronized fall is a press.
      @(negedge CLOCK_50);
      KEY[1] = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      KEY[1] = 1'b1;
      @(negedge CLOCK_50);
      KEY[1] = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      KEY[1] = 1'b1;
      repeat (6) @(negedge CLOCK_50);
      checkOutput("bounce_two_pulses", 64'(HEX), 64'(digits(13, 12, 8, 13, 0, 3)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
